ex_mem_stage: RTL

- Pipeline register and data-memory access controller between the execute stage and the memory/write-back register.
- Captures the EX results: ALU output, store data, write-back controls, npc, LUI and halt.
- Drives the data-memory request, holding it until dhit, and raises mem_busy to the hazard unit so upstream stages freeze.
- Captures returned load data for the MEM/WB register.

---
 rtl/ex_mem_stage.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register and data-memory access controller.
// Optional EX_MEM_STALL_CNT_EN adds stall_cnt/access_cnt performance counters.
module ex_mem_stage #(
  parameter int WORD_W = 32,
  parameter int RSEL_W = 5,
  parameter int WMUX_W = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              pipe3_en,
  input  logic              flush3,
  input  logic [WORD_W-1:0] npc_i3,
  input  logic [WORD_W-1:0] alu_out_i3,
  input  logic [WORD_W-1:0] rdat2_i3,
  input  logic [WORD_W-1:0] LUI_i3,
  input  logic [RSEL_W-1:0] wsel_i3,
  input  logic              wen_i3,
  input  logic [WMUX_W-1:0] W_mux_i3,
  input  logic              d_ren_i3,
  input  logic              d_wen_i3,
  input  logic              halt_i3,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic [WORD_W-1:0] npc_o3,
  output logic [WORD_W-1:0] alu_out_o3,
  output logic [WORD_W-1:0] LUI_o3,
  output logic [WORD_W-1:0] dmemload_o3,
  output logic [RSEL_W-1:0] wsel_o3,
  output logic              wen_o3,
  output logic [WMUX_W-1:0] W_mux_o3,
  output logic              halt_o3,
  output logic              mem_busy
`ifdef EX_MEM_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       access_cnt
`endif
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   npc_q, alu_q, rdat2_q, lui_q, dload_q;
  logic [RSEL_W-1:0]   wsel_q;
  logic [WMUX_W-1:0]   wmux_q;
  logic                wen_q, dren_q, dwen_q, halt_q;

  logic accept, bubble, start_mem, done;

  assign mem_busy  = (state_q == ACCESS) & ~dhit;
  assign accept    = pipe3_en & ~mem_busy;
  // Once halted, every later instruction is squashed so halt stays sticky.
  assign bubble    = flush3 | halt_q;
  assign start_mem = accept & ~bubble & (d_ren_i3 | d_wen_i3);
  assign done      = (state_q == ACCESS) & dhit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_mem) state_d = ACCESS;
      ACCESS:  if (dhit)      state_d = start_mem ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      npc_q   <= '0;
      alu_q   <= '0;
      rdat2_q <= '0;
      lui_q   <= '0;
      dload_q <= '0;
      wsel_q  <= '0;
      wmux_q  <= '0;
      wen_q   <= 1'b0;
      dren_q  <= 1'b0;
      dwen_q  <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      // Load data is captured before the register may be overwritten on the same edge.
      if (done && dren_q) dload_q <= dmemload;
      if (accept) begin
        if (bubble) begin
          npc_q   <= '0;
          alu_q   <= '0;
          rdat2_q <= '0;
          lui_q   <= '0;
          wsel_q  <= '0;
          wmux_q  <= '0;
          wen_q   <= 1'b0;
          dren_q  <= 1'b0;
          dwen_q  <= 1'b0;
          halt_q  <= halt_q;
        end else begin
          npc_q   <= npc_i3;
          alu_q   <= alu_out_i3;
          rdat2_q <= rdat2_i3;
          lui_q   <= LUI_i3;
          wsel_q  <= wsel_i3;
          wmux_q  <= W_mux_i3;
          wen_q   <= wen_i3;
          dren_q  <= d_ren_i3;
          dwen_q  <= d_wen_i3;
          halt_q  <= halt_i3;
        end
      end
    end
  end

  assign dmemREN     = (state_q == ACCESS) & dren_q;
  assign dmemWEN     = (state_q == ACCESS) & dwen_q & ~dren_q;
  assign dmemaddr    = alu_q;
  assign dmemstore   = rdat2_q;
  assign npc_o3      = npc_q;
  assign alu_out_o3  = alu_q;
  assign LUI_o3      = lui_q;
  assign dmemload_o3 = dload_q;
  assign wsel_o3     = wsel_q;
  assign wen_o3      = wen_q;
  assign W_mux_o3    = wmux_q;
  assign halt_o3     = halt_q;

`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] stall_q, access_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_q  <= '0;
      access_q <= '0;
    end else begin
      if (mem_busy && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
      if (done) access_q <= access_q + 32'd1;
    end
  end

  assign stall_cnt  = stall_q;
  assign access_cnt = access_q;
`endif

endmodule
